// File: rtl/apb_master_pkg.sv
// Shared bus-initiator definitions: APB transfer phases and default abort limit.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int unsigned APB_TIMEOUT_DEFAULT = 16;
  // Wide enough for the largest legal TIMEOUT (255).
  localparam int unsigned APB_WAIT_W = 8;

endpackage

// File: rtl/apb_master.sv
// Single-outstanding APB initiator: request/response handshake on one side,
// APB SETUP/ACCESS sequencing with wait-state timeout on the other.
module apb_master
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = APB_TIMEOUT_DEFAULT
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_stb,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pdata,
  output logic                    pwrite,
  output logic [DATA_WIDTH/8-1:0] pstb,
  output logic                    psel,
  output logic                    penable,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    perr
);

  localparam logic [APB_WAIT_W-1:0] WAIT_LIMIT = APB_WAIT_W'(TIMEOUT - 1);

  apb_state_t              r_state;
  apb_state_t              w_next;
  logic                    w_accept;
  logic                    w_done;
  logic                    w_abort;
  logic [APB_WAIT_W-1:0]   r_wait;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic [DATA_WIDTH-1:0]   r_pdata;
  logic                    r_pwrite;
  logic [DATA_WIDTH/8-1:0] r_pstb;
  logic                    r_resp_valid;
  logic [DATA_WIDTH-1:0]   r_resp_rdata;
  logic                    r_resp_err;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_done   = 1'b0;
    w_abort  = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = SETUP;
        end
      end
      SETUP: w_next = ACCESS;
      ACCESS: begin
        // A late pready on the limit cycle still wins over the timeout.
        if (pready) begin
          w_done = 1'b1;
          w_next = IDLE;
        end else if (r_wait == WAIT_LIMIT) begin
          w_abort = 1'b1;
          w_next  = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_wait <= '0;
    end else if (w_accept) begin
      r_wait <= '0;
    end else if (r_state == ACCESS && !pready) begin
      r_wait <= r_wait + 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_paddr  <= '0;
      r_pdata  <= '0;
      r_pwrite <= 1'b0;
      r_pstb   <= '0;
    end else if (w_accept) begin
      r_paddr  <= req_addr;
      r_pdata  <= req_wdata;
      r_pwrite <= req_write;
      r_pstb   <= req_stb;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= w_done | w_abort;
      if (w_done) begin
        r_resp_rdata <= r_pwrite ? '0 : prdata;
        r_resp_err   <= perr;
      end else if (w_abort) begin
        r_resp_rdata <= '0;
        r_resp_err   <= 1'b1;
      end
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign psel       = (r_state != IDLE);
  assign penable    = (r_state == ACCESS);
  assign paddr      = r_paddr;
  assign pdata      = r_pdata;
  assign pwrite     = r_pwrite;
  assign pstb       = r_pstb;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboarded bench for apb_master: directed scenarios plus random traffic
// against a scripted APB responder and a transaction-level reference model.
module tb_apb_master;

  localparam int unsigned TB_TIMEOUT = 4;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_stb;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] paddr, pdata, prdata;
  logic        pwrite, psel, penable, pready, perr;
  logic [3:0]  pstb;

  always #5 pclk = ~pclk;

  apb_master #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT   (TB_TIMEOUT)
  ) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_stb   (req_stb),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .paddr     (paddr),
    .pdata     (pdata),
    .pwrite    (pwrite),
    .pstb      (pstb),
    .psel      (psel),
    .penable   (penable),
    .prdata    (prdata),
    .pready    (pready),
    .perr      (perr)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [3:0]  stb;
    int unsigned waits;
    logic        err;
    logic        hang;
  } txn_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  txn_t        cfg_q[$];
  logic [31:0] ref_mem[64];
  logic [31:0] slv_mem[64];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_accepted = 0;
  int unsigned n_setups = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] stb);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (stb[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic txn_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic write, input logic [3:0] stb,
                              input int unsigned waits, input logic err, input logic hang);
    txn_t t;
    t.addr = addr; t.wdata = wdata; t.write = write; t.stb = stb;
    t.waits = waits; t.err = err; t.hang = hang;
    return t;
  endfunction

  // Caller is at a negedge; returns at the negedge after acceptance with req_valid still high.
  task automatic send(input txn_t t);
    int unsigned g;
    exp_t        e;
    logic        timeout;
    logic [31:0] m;
    req_valid = 1'b1;
    req_write = t.write;
    req_addr  = t.addr;
    req_wdata = t.wdata;
    req_stb   = t.stb;
    g = 0;
    while (!req_ready && g < 50) begin
      @(negedge pclk);
      g++;
    end
    if (!req_ready) begin
      chk("req_ready_wait", {63'd0, req_ready}, 64'd1);
      return;
    end
    @(posedge pclk);
    timeout = t.hang || (t.waits >= TB_TIMEOUT);
    m       = lane_mask(t.stb);
    e.err   = timeout || t.err;
    e.rdata = (timeout || t.write) ? 32'h0 : (ref_mem[t.addr[7:2]] & m);
    e.cyc   = 1 + (timeout ? TB_TIMEOUT : t.waits + 1);
    if (t.write && !timeout && !t.err)
      ref_mem[t.addr[7:2]] = (ref_mem[t.addr[7:2]] & ~m) | (t.wdata & m);
    exp_q.push_back(e);
    cfg_q.push_back(t);
    n_accepted++;
    @(negedge pclk);
  endtask

  task automatic drain();
    int unsigned g;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge pclk);
      g++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    @(negedge pclk);
  endtask

  // Scripted responder: per-transaction wait count, error and never-ready behaviour.
  txn_t        cur;
  int unsigned acc;
  logic        rdy;
  always @(negedge pclk) begin
    if (!presetn) begin
      pready = 1'b0; perr = 1'b0; prdata = '0; acc = 0;
    end else if (psel && !penable) begin
      pready = 1'($urandom);
      perr   = 1'($urandom);
      prdata = $urandom;
      acc    = 0;
      if (cfg_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_setup: SETUP phase with no accepted request at %0t", $time);
      end else begin
        cur = cfg_q.pop_front();
        n_setups++;
        chk("setup_addr",  64'(paddr),  64'(cur.addr));
        chk("setup_write", 64'(pwrite), 64'(cur.write));
        chk("setup_stb",   64'(pstb),   64'(cur.stb));
        chk("setup_wdata", 64'(pdata),  64'(cur.wdata));
      end
    end else if (psel && penable) begin
      chk("access_hold", 64'({paddr, pstb, pwrite}), 64'({cur.addr, cur.stb, cur.write}));
      rdy    = !cur.hang && (acc >= cur.waits);
      pready = rdy;
      perr   = rdy ? cur.err : 1'($urandom);
      prdata = (rdy && !pwrite) ? (slv_mem[paddr[7:2]] & lane_mask(pstb)) : $urandom;
      if (rdy && pwrite && !cur.err)
        for (int b = 0; b < 4; b++)
          if (pstb[b]) slv_mem[paddr[7:2]][b*8 +: 8] = pdata[b*8 +: 8];
      acc++;
    end else begin
      pready = 1'b0; perr = 1'b0;
    end
  end

  // Response monitor / scoreboard.
  int unsigned psel_cnt, pen_cnt;
  logic        ready_bad, hold_bad, last_er;
  logic [31:0] last_rd;
  exp_t        e_mon;
  always @(negedge pclk) begin
    if (!presetn) begin
      psel_cnt = 0; pen_cnt = 0; ready_bad = 0; hold_bad = 0; last_rd = '0; last_er = 0;
    end else begin
      if (psel) begin
        psel_cnt++;
        if (penable) pen_cnt++;
        if (req_ready) ready_bad = 1'b1;
      end
      if (!resp_valid) begin
        if (resp_rdata !== last_rd || resp_err !== last_er) hold_bad = 1'b1;
      end else if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_resp: resp_valid=1 rdata=0x%0h with no pending request at %0t",
                 resp_rdata, $time);
      end else begin
        e_mon = exp_q.pop_front();
        chk("resp_rdata",   64'(resp_rdata), 64'(e_mon.rdata));
        chk("resp_err",     64'(resp_err),   64'(e_mon.err));
        chk("psel_cycles",  64'(psel_cnt),   64'(e_mon.cyc));
        chk("pen_cycles",   64'(pen_cnt),    64'(e_mon.cyc - 1));
        chk("psel_dropped", 64'({psel, penable}), 64'd0);
        chk("ready_in_xfer", 64'(ready_bad), 64'd0);
        chk("resp_hold",    64'(hold_bad),   64'd0);
        last_rd = resp_rdata; last_er = resp_err;
        psel_cnt = 0; pen_cnt = 0; ready_bad = 0; hold_bad = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    int unsigned g;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_5A5A;
      slv_mem[i] = ref_mem[i];
    end
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_stb = '0;

    @(negedge pclk);
    chk("rst_psel",    64'(psel),       64'd0);
    chk("rst_penable", 64'(penable),    64'd0);
    chk("rst_paddr",   64'(paddr),      64'd0);
    chk("rst_pdata",   64'(pdata),      64'd0);
    chk("rst_pstb",    64'(pstb),       64'd0);
    chk("rst_pwrite",  64'(pwrite),     64'd0);
    chk("rst_rvalid",  64'(resp_valid), 64'd0);
    chk("rst_rdata",   64'(resp_rdata), 64'd0);
    chk("rst_rerr",    64'(resp_err),   64'd0);
    chk("rst_ready",   64'(req_ready),  64'd1);
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);

    send(mk(32'h10, 32'hDEAD_BEEF, 1'b1, 4'hF, 1, 1'b0, 1'b0));
    req_valid = 0;
    drain();
    chk("mem_word4", 64'(slv_mem[4]), 64'hDEAD_BEEF);

    send(mk(32'h10, 32'h0, 1'b0, 4'h3, 0, 1'b0, 1'b0));
    req_valid = 0;
    drain();

    send(mk(32'h20, 32'h0, 1'b0, 4'hF, 0, 1'b0, 1'b1));
    req_valid = 0;
    drain();

    send(mk(32'h30, 32'h1234_5678, 1'b1, 4'hF, 0, 1'b1, 1'b0));
    req_valid = 0;
    drain();

    // Boundary: pready arrives on the last permitted ACCESS cycle.
    send(mk(32'h34, 32'h0, 1'b0, 4'hC, TB_TIMEOUT - 1, 1'b0, 1'b0));
    req_valid = 0;
    drain();

    for (int i = 0; i < 3; i++)
      send(mk(32'h40 + 32'(i) * 4, 32'hC0DE_0000 + 32'(i), 1'b1, 4'hF, i, 1'b0, 1'b0));
    req_valid = 0;
    drain();
    chk("b2b_setups", 64'(n_setups), 64'(n_accepted));

    send(mk(32'h50, 32'h0, 1'b0, 4'hF, 0, 1'b0, 1'b1));
    req_valid = 0;
    g = 0;
    while (!penable && g < 10) begin
      @(negedge pclk);
      g++;
    end
    chk("rst_reach_access", 64'(penable), 64'd1);
    #2 presetn = 1'b0;
    #1;
    chk("midrst_psel",    64'(psel),    64'd0);
    chk("midrst_penable", 64'(penable), 64'd0);
    chk("midrst_paddr",   64'(paddr),   64'd0);
    exp_q.delete();
    cfg_q.delete();
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    chk("ready_after_rst", 64'(req_ready), 64'd1);
    repeat (3) @(negedge pclk);

    for (int i = 0; i < 40; i++) begin
      t = mk(($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 63)) << 2), $urandom,
             1'($urandom), 4'($urandom_range(1, 15)), $urandom_range(0, 5),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 1) == 1) begin
        req_valid = 0;
        repeat ($urandom_range(0, 3)) @(negedge pclk);
      end
      send(t);
    end
    req_valid = 0;
    drain();
    chk("setup_count", 64'(n_setups), 64'(n_accepted));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the paddr/req_addr width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the data bus width; DATA_WIDTH/8 strobe bits.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, meaning ACCESS cycles without pready before abort; legal range 2..255.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL provide port pclk, input, 1, the single clock; all logic on its rising edge.
REQ-006 The block SHALL provide port presetn, input, 1, the asynchronous active-low reset.
REQ-007 The block SHALL provide these request-side ports: req_valid in 1; req_ready out 1; req_write in 1; req_addr in ADDR_WIDTH; req_wdata in DATA_WIDTH; req_stb in 4 (byte-lane mask).
REQ-008 The block SHALL provide these response-side ports: resp_valid out 1; resp_rdata out DATA_WIDTH; resp_err out 1.
REQ-009 The block SHALL provide these bus-side ports: paddr out ADDR_WIDTH; pdata out DATA_WIDTH; pwrite out 1; pstb out 4; psel out 1; penable out 1; prdata in DATA_WIDTH; pready in 1; perr in 1.

Function
REQ-010 The FSM SHALL have three states: IDLE, SETUP, and ACCESS.
REQ-011 The block SHALL drive req_ready = 1 only in IDLE; a request is accepted on a cycle where req_valid && req_ready.
REQ-012 On acceptance, the block SHALL register req_addr, req_wdata, req_write, and req_stb onto paddr, pdata, pwrite, and pstb, then go to SETUP.
REQ-013 SETUP SHALL drive psel=1 and penable=0, and SHALL move unconditionally to ACCESS after one cycle; pready/perr in SETUP are ignored.
REQ-014 ACCESS SHALL drive psel=1 and penable=1, and SHALL stay in ACCESS while pready=0 (wait states).
REQ-015 paddr, pdata, pwrite, and pstb SHALL remain stable from SETUP until the cycle after completion; pstb carries the byte-lane mask for reads and for writes.
REQ-016 Completion SHALL occur when the block samples pready=1 in ACCESS; on that edge psel and penable drop to 0 and the FSM returns to IDLE.
REQ-017 On completion, resp_valid SHALL pulse for exactly one cycle, with resp_rdata = prdata sampled at completion for reads, or 0 for writes.
REQ-018 On completion, resp_err SHALL equal perr sampled with pready; perr is ignored when pready=0.
REQ-019 A wait counter SHALL clear on SETUP entry and increment each ACCESS cycle with pready=0.
REQ-020 When the wait counter reaches TIMEOUT-1 with pready still 0, the block SHALL abort: psel/penable drop, resp_valid=1, resp_err=1, resp_rdata=0, return to IDLE.
REQ-021 If pready rises on the same cycle the counter hits its limit, the block SHALL complete normally and SHALL NOT time out.
REQ-022 Minimum transfer time SHALL be 3 cycles (accept, SETUP, ACCESS); back-to-back requests SHALL insert no further bubble beyond returning to IDLE.
REQ-023 resp_rdata and resp_err SHALL hold their value until the next response.

Reset
REQ-024 While presetn=0, the block SHALL force state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pdata=0, pstb=0, resp_valid=0, resp_err=0, resp_rdata=0, and wait counter=0, immediately and asynchronously.
REQ-025 Reset asserted mid-transfer SHALL abandon the transfer with no response pulse; req_ready SHALL be 1 on the first cycle after presetn deasserts.

Structure
REQ-026 The FSM state encoding (IDLE/SETUP/ACCESS) and the default TIMEOUT constant SHALL live in a shared bus package, for reuse by other bus initiators.
REQ-027 No sub-module is required; the FSM, wait counter, and output registers SHALL be implemented in one module.

Verification
REQ-028 The bench SHALL cover a write: addr 0x10, wdata 0xDEADBEEF, stb 4'hF, responder pready after 1 wait -> psel high 3 cycles; penable high the final 2; resp_valid=1, resp_err=0; the memory word at index 4 = 0xDEADBEEF.
REQ-029 The bench SHALL cover a read: addr 0x10, stb 4'h3 -> pstb=4'h3 through the transfer; resp_rdata=0x0000BEEF, resp_err=0.
REQ-030 The bench SHALL cover a timeout: responder never raises pready, TIMEOUT=4 -> abort after 4 ACCESS cycles with resp_err=1, resp_rdata=0; psel low on the next cycle.
REQ-031 The bench SHALL cover an error: pready=1 with perr=1 on the first ACCESS cycle -> 3-cycle transfer; resp_err=1.
REQ-032 The bench SHALL cover back-to-back traffic: req_valid held high for 3 writes -> 3 distinct SETUP phases, req_ready low during each transfer, 3 resp_valid pulses in order.
REQ-033 The bench SHALL cover reset mid-transfer: presetn low during ACCESS -> psel/penable low in the same cycle, no resp_valid pulse, req_ready=1 after release.
